imm_encoder: RTL

- Inverse of the immediate decoder. Takes an instruction template plus a 32-bit immediate and a type code, then scatters the immediate into the RV32I bit positions for that format.
- Also expands a load-immediate pseudo-op into ADDI or LUI(+ADDI).
- Sits between the boot/debug loader and instruction memory write port.
- Valid/ready on both sides; registered output, one-entry skid.

---
 rtl/imm_encoder.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/imm_encoder.sv
// Scatters a 32-bit immediate into the RV32I bit positions of an instruction template,
// and expands load-immediate into ADDI or LUI(+ADDI). Optional feature macro: ROUNDTRIP_CHECK_EN.
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef I_TYPE_IMM
`define I_TYPE_IMM 3'd0
`endif
`ifndef S_TYPE_IMM
`define S_TYPE_IMM 3'd1
`endif
`ifndef B_TYPE_IMM
`define B_TYPE_IMM 3'd2
`endif
`ifndef U_TYPE_IMM
`define U_TYPE_IMM 3'd3
`endif
`ifndef J_TYPE_IMM
`define J_TYPE_IMM 3'd4
`endif

module imm_encoder #(
  parameter logic [2:0] LI_TYPE = 3'b111
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_type,
  input  logic [`INSTR_WIDTH-1:0]  in_base,
  input  logic [`DATA_WIDTH-1:0]   in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [`INSTR_WIDTH-1:0]  out_instr,
  output logic                     out_last,
  output logic                     out_err
`ifdef ROUNDTRIP_CHECK_EN
  ,
  output logic                     chk_fail
`endif
);

  typedef enum logic {IDLE, SECOND} state_t;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  state_t state, state_next;
  logic   accept;

  logic [31:0] enc_instr;
  logic        enc_err, enc_last, enc_two;
  logic [31:0] enc_pend;
  logic [31:0] pend_instr;
  logic [4:0]  rd;
  logic [11:0] lo;
  logic [19:0] hi;
  logic        fits12, fits13, fits21;

  assign rd     = in_base[11:7];
  assign lo     = in_imm[11:0];
  assign hi     = in_imm[31:12] + {19'd0, in_imm[11]};
  // A value fits an N-bit signed field when all bits above N-1 copy the sign bit.
  assign fits12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign fits13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign fits21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  assign accept = in_valid & in_ready;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    enc_instr = in_base;
    enc_err   = 1'b0;
    enc_last  = 1'b1;
    enc_two   = 1'b0;
    enc_pend  = {lo, rd, 3'b000, rd, OP_IMM};
    if (in_type == LI_TYPE) begin
      if (fits12) begin
        enc_instr = {lo, 5'd0, 3'b000, rd, OP_IMM};
      end else begin
        enc_instr = {hi, rd, OP_LUI};
        enc_two   = (lo != 12'd0);
        enc_last  = (lo == 12'd0);
      end
    end else begin
      case (in_type)
        `I_TYPE_IMM: begin
          enc_instr = {in_imm[11:0], in_base[19:0]};
          enc_err   = ~fits12;
        end
        `S_TYPE_IMM: begin
          enc_instr = {in_imm[11:5], in_base[24:12], in_imm[4:0], in_base[6:0]};
          enc_err   = ~fits12;
        end
        `B_TYPE_IMM: begin
          enc_instr = {in_imm[12], in_imm[10:5], in_base[24:12], in_imm[4:1], in_imm[11], in_base[6:0]};
          enc_err   = ~fits13 | in_imm[0];
        end
        `U_TYPE_IMM: begin
          enc_instr = {in_imm[31:12], in_base[11:0]};
          enc_err   = (in_imm[11:0] != 12'd0);
        end
        `J_TYPE_IMM: begin
          enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_base[11:0]};
          enc_err   = ~fits21 | in_imm[0];
        end
        default: begin
          enc_instr = in_base;
          enc_err   = 1'b1;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && enc_two)      state_next = SECOND;
      SECOND:  if (out_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE) & (~out_valid | out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_last   <= 1'b0;
      out_err    <= 1'b0;
      pend_instr <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_instr  <= enc_instr;
      out_last   <= enc_last;
      out_err    <= enc_err;
      pend_instr <= enc_pend;
    end else if (state == SECOND && out_ready) begin
      out_valid <= 1'b1;
      out_instr <= pend_instr;
      out_last  <= 1'b1;
      out_err   <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ROUNDTRIP_CHECK_EN
  // Decode the registered word again and compare against the value it was meant to carry.
  logic [2:0]  chk_type, enc_chk_type, pend_chk_type;
  logic [31:0] exp_imm, enc_exp, pend_exp;
  logic [31:0] dec_imm;

  always_comb begin
    enc_chk_type = in_type;
    enc_exp      = in_imm;
    if (in_type == LI_TYPE) begin
      enc_chk_type = fits12 ? `I_TYPE_IMM : `U_TYPE_IMM;
      enc_exp      = fits12 ? in_imm : {hi, 12'd0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_type      <= '0;
      exp_imm       <= '0;
      pend_chk_type <= '0;
      pend_exp      <= '0;
    end else if (accept) begin
      chk_type      <= enc_chk_type;
      exp_imm       <= enc_exp;
      pend_chk_type <= `I_TYPE_IMM;
      pend_exp      <= {{20{lo[11]}}, lo};
    end else if (state == SECOND && out_ready) begin
      chk_type <= pend_chk_type;
      exp_imm  <= pend_exp;
    end
  end

  ImmGen u_imm_gen (
    .Instr    (out_instr),
    .Imm_Type (chk_type),
    .Imm      (dec_imm)
  );

  assign chk_fail = out_valid & ~out_err & (dec_imm != exp_imm);
`endif

endmodule
